// File: rtl/display_timings.sv
// Parametrised raster timing generator: screen position, syncs, data enable,
// line/frame strobes, frame counter and a delayed sync/de copy for pixel pipelines.
module display_timings #(
    parameter int unsigned CORDW      = 10,
    parameter int unsigned H_RES      = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          H_POL      = 1'b0,
    parameter bit          V_POL      = 1'b0,
    parameter int unsigned PIPE_DELAY = 2,
    parameter int unsigned FCW        = 16
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line,
    output logic             frame,
    output logic [FCW-1:0]   frame_count,
    output logic             hsync_d,
    output logic             vsync_d,
    output logic             de_d
);

    localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_STA  = H_RES + H_FP;
    localparam int unsigned HS_END  = HS_STA + H_SYNC - 1;
    localparam int unsigned VS_STA  = V_RES + V_FP;
    localparam int unsigned VS_END  = VS_STA + V_SYNC - 1;

    localparam longint unsigned COORD_CAP = 64'd1 << CORDW;

    localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_RES_C  = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_RES_C  = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_STA_C = CORDW'(HS_STA);
    localparam logic [CORDW-1:0] HS_END_C = CORDW'(HS_END);
    localparam logic [CORDW-1:0] VS_STA_C = CORDW'(VS_STA);
    localparam logic [CORDW-1:0] VS_END_C = CORDW'(VS_END);

    // Delay-line word is {hsync, vsync, de}; idle value is syncs inactive, de low.
    localparam int unsigned DLY_W    = 3;
    localparam logic [DLY_W-1:0] DLY_IDLE = {~H_POL, ~V_POL, 1'b0};

    generate
        if (64'(H_TOTAL - 1) >= COORD_CAP || 64'(V_TOTAL - 1) >= COORD_CAP) begin : g_cordw_too_small
            $error("display_timings: CORDW too narrow for H_TOTAL/V_TOTAL");
        end
    endgenerate

    logic [CORDW-1:0] sx_n;
    logic [CORDW-1:0] sy_n;
    logic             hsync_n;
    logic             vsync_n;
    logic             de_n;
    logic             line_n;
    logic             frame_n;

    // Next position and its decode, so every output pin comes straight from a flop.
    always_comb begin
        sx_n    = sx + CORDW'(1);
        sy_n    = sy;
        if (sx == H_LAST) begin
            sx_n = '0;
            sy_n = (sy == V_LAST) ? '0 : sy + CORDW'(1);
        end
        hsync_n = ((sx_n >= HS_STA_C) && (sx_n <= HS_END_C)) ? H_POL : ~H_POL;
        vsync_n = ((sy_n >= VS_STA_C) && (sy_n <= VS_END_C)) ? V_POL : ~V_POL;
        de_n    = (sx_n < H_RES_C) && (sy_n < V_RES_C);
        line_n  = (sx_n == '0);
        frame_n = line_n && (sy_n == '0);
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            sx          <= H_LAST;
            sy          <= V_LAST;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            de          <= 1'b0;
            line        <= 1'b0;
            frame       <= 1'b0;
            frame_count <= '1;
        end else begin
            sx    <= sx_n;
            sy    <= sy_n;
            hsync <= hsync_n;
            vsync <= vsync_n;
            de    <= de_n;
            line  <= line_n;
            frame <= frame_n;
            if (frame_n) begin
                frame_count <= frame_count + FCW'(1);
            end
        end
    end

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign hsync_d = hsync;
            assign vsync_d = vsync;
            assign de_d    = de;
        end else begin : g_delay
            logic [DLY_W-1:0] pipe [PIPE_DELAY];

            always_ff @(posedge clk_pix or posedge rst_pix) begin
                if (rst_pix) begin
                    for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
                        pipe[i] <= DLY_IDLE;
                    end
                end else begin
                    pipe[0] <= {hsync, vsync, de};
                    for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign {hsync_d, vsync_d, de_d} = pipe[PIPE_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_display_timings.sv
// Randomized-reset bench for display_timings: three modes checked every cycle
// against a position-from-elapsed-cycles model, plus literal spot checks.
module tb_display_timings;

    typedef struct {
        int hr, hfp, hsw, hbp;
        int vr, vfp, vsw, vbp;
        bit hp, vp;
        int pd, fcw;
    } cfg_t;

    typedef struct {
        int sx, sy;
        bit hs, vs, de, ln, fr;
        int fc;
    } pos_t;

    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;
    bit   run  = 1'b0;

    cfg_t c0, c1, c2;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   t0    = -1;
    int   t1    = -1;
    int   t2    = -1;

    always #5 clk = ~clk;

    // DUT 0: default 640x480 timing
    logic [9:0]  sx0, sy0;
    logic        hs0, vs0, de0, ln0, fr0, hsd0, vsd0, ded0;
    logic [15:0] fc0;
    display_timings u0 (
        .clk_pix(clk), .rst_pix(rst0), .sx(sx0), .sy(sy0), .hsync(hs0), .vsync(vs0),
        .de(de0), .line(ln0), .frame(fr0), .frame_count(fc0),
        .hsync_d(hsd0), .vsync_d(vsd0), .de_d(ded0)
    );

    // DUT 1: mid-size mode, positive syncs, 3-stage delay
    logic [7:0]  sx1, sy1;
    logic        hs1, vs1, de1, ln1, fr1, hsd1, vsd1, ded1;
    logic [3:0]  fc1;
    display_timings #(
        .CORDW(8), .H_RES(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_RES(48), .V_FP(3), .V_SYNC(2), .V_BP(5),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(3), .FCW(4)
    ) u1 (
        .clk_pix(clk), .rst_pix(rst1), .sx(sx1), .sy(sy1), .hsync(hs1), .vsync(vs1),
        .de(de1), .line(ln1), .frame(fr1), .frame_count(fc1),
        .hsync_d(hsd1), .vsync_d(vsd1), .de_d(ded1)
    );

    // DUT 2: tiny mode, 2-bit frame counter, no delay
    logic [3:0]  sx2, sy2;
    logic        hs2, vs2, de2, ln2, fr2, hsd2, vsd2, ded2;
    logic [1:0]  fc2;
    display_timings #(
        .CORDW(4), .H_RES(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIPE_DELAY(0), .FCW(2)
    ) u2 (
        .clk_pix(clk), .rst_pix(rst2), .sx(sx2), .sy(sy2), .hsync(hs2), .vsync(vs2),
        .de(de2), .line(ln2), .frame(fr2), .frame_count(fc2),
        .hsync_d(hsd2), .vsync_d(vsd2), .de_d(ded2)
    );

    // Cycles since reset release; -1 while in reset.
    always @(posedge clk or posedge rst0) if (rst0) t0 <= -1; else t0 <= t0 + 1;
    always @(posedge clk or posedge rst1) if (rst1) t1 <= -1; else t1 <= t1 + 1;
    always @(posedge clk or posedge rst2) if (rst2) t2 <= -1; else t2 <= t2 + 1;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs t cycles after reset release (t < 0: reset state).
    function automatic pos_t model(cfg_t c, int t);
        pos_t p;
        int ht, vt, hs_sta, vs_sta;
        ht     = c.hr + c.hfp + c.hsw + c.hbp;
        vt     = c.vr + c.vfp + c.vsw + c.vbp;
        hs_sta = c.hr + c.hfp;
        vs_sta = c.vr + c.vfp;
        if (t < 0) begin
            p.sx = ht - 1;
            p.sy = vt - 1;
            p.hs = ~c.hp;
            p.vs = ~c.vp;
            p.de = 1'b0;
            p.ln = 1'b0;
            p.fr = 1'b0;
            p.fc = (1 << c.fcw) - 1;
        end else begin
            p.sx = t % ht;
            p.sy = (t / ht) % vt;
            p.fc = (t / (ht * vt)) % (1 << c.fcw);
            p.hs = (p.sx >= hs_sta && p.sx < hs_sta + c.hsw) ? c.hp : ~c.hp;
            p.vs = (p.sy >= vs_sta && p.sy < vs_sta + c.vsw) ? c.vp : ~c.vp;
            p.de = (p.sx < c.hr) && (p.sy < c.vr);
            p.ln = (p.sx == 0);
            p.fr = p.ln && (p.sy == 0);
        end
        return p;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(string tag, cfg_t c, int t,
                            logic [31:0] sx, logic [31:0] sy,
                            logic hs, logic vs, logic de, logic ln, logic fr,
                            logic [31:0] fc, logic hsd, logic vsd, logic ded);
        pos_t e, d;
        e = model(c, t);
        d = model(c, t - c.pd);
        check({tag, ".sx"},          sx,       32'(e.sx));
        check({tag, ".sy"},          sy,       32'(e.sy));
        check({tag, ".hsync"},       32'(hs),  32'(e.hs));
        check({tag, ".vsync"},       32'(vs),  32'(e.vs));
        check({tag, ".de"},          32'(de),  32'(e.de));
        check({tag, ".line"},        32'(ln),  32'(e.ln));
        check({tag, ".frame"},       32'(fr),  32'(e.fr));
        check({tag, ".frame_count"}, fc,       32'(e.fc));
        check({tag, ".hsync_d"},     32'(hsd), 32'(d.hs));
        check({tag, ".vsync_d"},     32'(vsd), 32'(d.vs));
        check({tag, ".de_d"},        32'(ded), 32'(d.de));
    endtask

    // Single compare process: all three DUTs against the model every cycle.
    always @(negedge clk) begin
        if (run) begin
            cmp_inst("u0", c0, t0, 32'(sx0), 32'(sy0), hs0, vs0, de0, ln0, fr0, 32'(fc0), hsd0, vsd0, ded0);
            cmp_inst("u1", c1, t1, 32'(sx1), 32'(sy1), hs1, vs1, de1, ln1, fr1, 32'(fc1), hsd1, vsd1, ded1);
            cmp_inst("u2", c2, t2, 32'(sx2), 32'(sy2), hs2, vs2, de2, ln2, fr2, 32'(fc2), hsd2, vsd2, ded2);
        end
    end

    // First five u2 frame strobes after the initial release.
    int nq = 0;
    int fcs [5];
    int cys [5];
    always @(negedge clk) begin
        if (!rst2 && nq < 5 && fr2) begin
            fcs[nq] <= 32'(fc2);
            cys[nq] <= cyc;
            nq      <= nq + 1;
        end
    end

    initial begin
        pos_t p;
        int   target;
        int   exp_fc [5];
        exp_fc = '{0, 1, 2, 3, 0};

        c0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2, 16};
        c1 = '{64, 4, 8, 4, 48, 3, 2, 5, 1'b1, 1'b1, 3, 4};
        c2 = '{8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0, 0, 2};

        // Hand-computed pins on the model itself
        p = model(c0, -1);        check("model.rst.sx", 32'(p.sx), 799); check("model.rst.sy", 32'(p.sy), 524);
        p = model(c0, 0);         check("model.t0.frame", 32'(p.fr), 1); check("model.t0.de", 32'(p.de), 1);
        check("model.t0.fc", 32'(p.fc), 0);
        p = model(c0, 655);       check("model.hs655", 32'(p.hs), 1);
        p = model(c0, 656);       check("model.hs656", 32'(p.hs), 0);
        p = model(c0, 751);       check("model.hs751", 32'(p.hs), 0);
        p = model(c0, 752);       check("model.hs752", 32'(p.hs), 1);
        p = model(c0, 640);       check("model.de640", 32'(p.de), 0);
        p = model(c0, 800);       check("model.line800", 32'(p.ln), 1); check("model.sy800", 32'(p.sy), 1);
        p = model(c0, 490*800-1); check("model.vs_pre", 32'(p.vs), 1);
        p = model(c0, 490*800);   check("model.vs_sta", 32'(p.vs), 0);
        p = model(c0, 492*800);   check("model.vs_post", 32'(p.vs), 1);
        p = model(c0, 420000);    check("model.frame2", 32'(p.fr), 1); check("model.fc2", 32'(p.fc), 1);
        p = model(c2, 4*84);      check("model.small.fcwrap", 32'(p.fc), 0);

        run = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        @(posedge clk); #1;
        check("u0.first.sx", 32'(sx0), 0);
        check("u0.first.sy", 32'(sy0), 0);
        check("u0.first.frame", 32'(fr0), 1);
        check("u0.first.line", 32'(ln0), 1);
        check("u0.first.de", 32'(de0), 1);
        check("u0.first.fc", 32'(fc0), 0);
        @(posedge clk); #1;
        check("u0.second.frame", 32'(fr0), 0);
        check("u0.second.line", 32'(ln0), 0);

        // Bounded wait for u1 to sit one cycle before (70,20) of its third frame
        target = 2*4640 + 20*80 + 69;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (t1 == target) break;
        end
        check("u1.reach_target", 32'(t1), 32'(target));
        @(posedge clk); #2;
        rst1 = 1'b1;
        #1;
        check("u1.rst.sx", 32'(sx1), 79);
        check("u1.rst.sy", 32'(sy1), 57);
        check("u1.rst.de", 32'(de1), 0);
        check("u1.rst.hsync", 32'(hs1), 0);
        check("u1.rst.vsync", 32'(vs1), 0);
        check("u1.rst.de_d", 32'(ded1), 0);
        check("u1.rst.line", 32'(ln1), 0);
        repeat (3) @(negedge clk);
        #1;
        rst1 = 1'b0;
        @(posedge clk); #1;
        check("u1.restart.frame", 32'(fr1), 1);
        check("u1.restart.sx", 32'(sx1), 0);
        check("u1.restart.sy", 32'(sy1), 0);

        // u2 frame counter sequence and frame period
        check("u2.frames_seen", 32'(nq), 5);
        for (int i = 0; i < 5; i++) check("u2.fc_seq", 32'(fcs[i]), 32'(exp_fc[i]));
        for (int i = 1; i < 5; i++) check("u2.frame_gap", 32'(cys[i] - cys[i-1]), 84);

        // Random asynchronous resets at random phases and durations
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(50, 2500)) @(negedge clk);
            @(posedge clk);
            #($urandom_range(1, 4));
            rst0 = 1'b1;
            if (k % 2 == 1) rst2 = 1'b1;
            if (k % 3 == 2) rst1 = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            #1;
            rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        end
        repeat (300) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/display_timings.md
# display_timings

Parametrised raster timing generator for the pixel-clock domain, succeeding the fixed 640x480p60 generator. Produces screen coordinates, programmable-polarity syncs, data enable, line/frame start strobes and a frame counter. Also provides a delayed copy of hsync/vsync/de so sync timing stays aligned with a downstream pixel pipeline of known depth. All timings are elaboration-time parameters, so one block covers 480p, 720p and custom modes.

## Interface
- CORDW, 10: width of sx/sy. H_RES+H_FP+H_SYNC+H_BP-1 and V_RES+V_FP+V_SYNC+V_BP-1 must fit; elaboration error otherwise.
- H_RES, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_RES, 480: active lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- H_POL, 0: hsync active level (0 = active-low, 1 = active-high).
- V_POL, 0: vsync active level, same encoding as H_POL.
- PIPE_DELAY, 2: stages of delay on hsync_d/vsync_d/de_d; 0 is legal.
- FCW, 16: frame counter width.
- clk_pix  in  1  pixel clock; the only clock.
- rst_pix  in  1  reset, asynchronous, active-high.
- sx  out  CORDW  horizontal position, 0..H_TOTAL-1.
- sy  out  CORDW  vertical position, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, aligned with sx/sy.
- vsync  out  1  vertical sync, aligned with sx/sy.
- de  out  1  high in the active area, aligned with sx/sy.
- line  out  1  one-cycle strobe when sx==0 (every line, including blanking lines).
- frame  out  1  one-cycle strobe when sx==0 and sy==0.
- frame_count  out  FCW  frame index; wraps modulo 2^FCW.
- hsync_d  out  1  hsync delayed PIPE_DELAY cycles.
- vsync_d  out  1  vsync delayed PIPE_DELAY cycles.
- de_d  out  1  de delayed PIPE_DELAY cycles.

## Operation
- Derived constants:
  - H_TOTAL = H_RES+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - HS_STA = H_RES+H_FP; HS_END = HS_STA+H_SYNC-1. VS_STA/VS_END likewise.
- Counters:
  - sx increments every cycle. At H_TOTAL-1, sx wraps to 0 and sy advances.
  - sy wraps from V_TOTAL-1 to 0.
  - Counter arithmetic is unsigned CORDW bits; wrap is by compare, not overflow.
- Outputs are registered and describe the current sx/sy. The next-state values are decoded one cycle early, so no combinational path runs from the counters to the pins.
  - hsync = H_POL when HS_STA <= sx <= HS_END, else ~H_POL. vsync likewise on sy with V_POL.
  - de = (sx < H_RES) && (sy < V_RES).
- frame_count increments on the cycle the position becomes (0,0), coincident with frame.
- Delay line:
  - A PIPE_DELAY-deep shift register of {hsync,vsync,de}.
  - With PIPE_DELAY = 0, the _d outputs equal the undelayed outputs.
- Reset (asserted, asynchronous, takes effect immediately, including mid-line or mid-frame):
  - sx = H_TOTAL-1, sy = V_TOTAL-1.
  - hsync = ~H_POL, vsync = ~V_POL, de = 0, line = 0, frame = 0.
  - frame_count = all ones.
  - Every delay stage holds {~H_POL, ~V_POL, 0}.
- First rising edge after reset release: position becomes (0,0), frame=1, line=1, de=1, frame_count=0.

## Timing
- Latency:
  - Position to hsync/vsync/de/line/frame: 0 cycles (same cycle).
  - To the _d outputs: exactly PIPE_DELAY cycles.
- Line period is H_TOTAL cycles. Frame period is H_TOTAL*V_TOTAL cycles (420000 for defaults).
- hsync is active for exactly H_SYNC consecutive cycles per line. vsync is active for exactly V_SYNC*H_TOTAL cycles, starting at sx==0 of line VS_STA.
- frame and line are coincident at (0,0). No strobe is produced during reset.
- frame_count wrap: all ones -> 0 with no other effect.

## Test plan
- Reset release, defaults -> first edge: sx=0, sy=0, frame=1, line=1, de=1, frame_count=0. Next cycle: frame=0, line=0.
- Run one line -> de high for sx 0..639. hsync low for sx 656..751 (96 cycles). Next line=1 exactly 800 cycles later.
- Run two frames -> vsync low for sy 490..491 (1600 cycles). Frame strobes 420000 cycles apart; frame_count reads 1 at the second strobe.
- PIPE_DELAY=3, H_POL=1, V_POL=1 -> hsync high for sx 656..751. hsync_d/vsync_d/de_d equal the undelayed signals from 3 cycles earlier for a full frame.
- Assert rst_pix between clock edges at sx=700, sy=100 -> immediately sx=799, sy=524, de=0, syncs inactive, de_d=0. After release, the sequence restarts at (0,0) with frame=1.
- FCW=2, small mode (H 8/1/2/1, V 4/1/1/1) -> frame_count goes 0,1,2,3,0 over five frames, with 84 cycles between frame strobes.
